// File: rtl/cpu_sequencer.sv
// Eight-phase CPU instruction sequencer: decodes datapath controls from the current phase and opcode,
// stretches memory phases until mem_ready, and halts on HLT or on a memory timeout.
module cpu_sequencer #(
    parameter int AC_W     = 8,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      opcode,
    input  logic [AC_W-1:0] ac,
    input  logic            mem_ready,
    input  logic            go,
    output logic [2:0]      phase,
    output logic            sel,
    output logic            rd,
    output logic            ld_ir,
    output logic            halt,
    output logic            inc_pc,
    output logic            ld_ac,
    output logic            wr,
    output logic            ld_pc,
    output logic            data_e,
    output logic            halted,
    output logic            bus_err
);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} st_t;

    localparam logic [2:0] OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    st_t             st_q, st_d;
    logic [2:0]      phase_q, phase_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            bus_err_q, bus_err_d;

    logic is_a, is_h, is_z, is_j, is_s, wait_ph;

    always_comb begin
        is_a    = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_XOR) || (opcode == OP_LDA);
        is_h    = (opcode == OP_HLT);
        is_z    = (opcode == OP_SKZ) && (ac == '0);
        is_j    = (opcode == OP_JMP);
        is_s    = (opcode == OP_STO);
        wait_ph = (phase_q == 3'd2) || ((phase_q == 3'd6) && (is_a || is_s));
    end

    always_comb begin
        st_d       = st_q;
        phase_d    = phase_q;
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = bus_err_q;
        if (st_q == HALTED) begin
            phase_d    = 3'd0;
            wait_cnt_d = '0;
            if (go) begin
                st_d      = RUN;
                bus_err_d = 1'b0;
            end
        end else if (wait_ph && !mem_ready) begin
            // A stall on the last allowed cycle becomes a bus error; WAIT_MAX=0 stalls forever.
            if (WAIT_MAX > 0) begin
                if (wait_cnt_q == WAIT_LAST) begin
                    st_d       = HALTED;
                    phase_d    = 3'd0;
                    wait_cnt_d = '0;
                    bus_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
        end else begin
            wait_cnt_d = '0;
            if ((phase_q == 3'd4) && is_h) begin
                st_d    = HALTED;
                phase_d = 3'd0;
            end else begin
                phase_d = phase_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q       <= RUN;
            phase_q    <= 3'd0;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            st_q       <= st_d;
            phase_q    <= phase_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        halted = 1'b0;
        if (st_q == HALTED) begin
            sel    = 1'b1;
            halted = 1'b1;
        end else begin
            case (phase_q)
                3'd0: sel = 1'b1;
                3'd1: begin sel = 1'b1; rd = 1'b1; end
                3'd2, 3'd3: begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
                3'd4: begin halt = is_h; inc_pc = 1'b1; end
                3'd5: rd = is_a;
                3'd6: begin rd = is_a; inc_pc = is_z; ld_pc = is_j; data_e = is_s; end
                default: begin rd = is_a; ld_ac = is_a; ld_pc = is_j; wr = is_s; data_e = is_s; end
            endcase
        end
    end

    assign phase   = (st_q == HALTED) ? 3'd0 : phase_q;
    assign bus_err = bus_err_q;

endmodule
